// File: rtl/secuencia_ctrl.sv
// Run-of-ones scheduler: captures a word, streams it LSB-first through a Moore
// run detector, counts detections, records the first hit and pulses done.
module secuencia_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned RUN_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [RUN_W-1:0] run_len,
  output logic             busy,
  output logic             w_out,
  output logic             z,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] first_pos,
  output logic             found
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [RUN_W-1:0] r_cfg;
  logic [IDX_W-1:0] r_idx;
  logic [RUN_W-1:0] r_run;
  logic [CNT_W-1:0] r_match_count;
  logic [CNT_W-1:0] r_first_pos;
  logic             r_found;
  logic             r_busy;
  logic             r_done;
  logic             r_w_out;
  logic             r_z;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_data_next;
  logic [RUN_W-1:0] w_cfg_next;
  logic [IDX_W-1:0] w_idx_next;
  logic [RUN_W-1:0] w_run_next;
  logic [CNT_W-1:0] w_match_count_next;
  logic [CNT_W-1:0] w_first_pos_next;
  logic             w_found_next;
  logic             w_busy_next;
  logic             w_done_next;
  logic             w_w_out_next;
  logic             w_z_next;

  logic             w_bit;
  logic [IDX_W-1:0] w_idx_inc;
  logic             w_last_bit;
  logic [RUN_W-1:0] w_run_sat;
  logic [RUN_W-1:0] w_run_upd;
  logic             w_hit;

  // Detector datapath for the bit presented this cycle; run saturates at cfg
  assign w_bit      = r_data[r_idx];
  assign w_idx_inc  = r_idx + IDX_W'(1);
  assign w_last_bit = (r_idx == IDX_W'(WIDTH - 1));
  assign w_run_sat  = (r_run >= r_cfg) ? r_cfg : (r_run + RUN_W'(1));
  assign w_run_upd  = w_bit ? w_run_sat : '0;
  assign w_hit      = (w_run_upd >= r_cfg);

  // Next-state and next-output logic; outputs are registered one step ahead
  always_comb begin
    w_state_next       = r_state;
    w_data_next        = r_data;
    w_cfg_next         = r_cfg;
    w_idx_next         = r_idx;
    w_run_next         = r_run;
    w_match_count_next = r_match_count;
    w_first_pos_next   = r_first_pos;
    w_found_next       = r_found;
    w_busy_next        = 1'b0;
    w_done_next        = 1'b0;
    w_w_out_next       = 1'b0;
    w_z_next           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next       = S_SHIFT;
          w_data_next        = data;
          w_cfg_next         = (run_len == '0) ? RUN_W'(1) : run_len;
          w_idx_next         = '0;
          w_run_next         = '0;
          w_match_count_next = '0;
          w_first_pos_next   = '0;
          w_found_next       = 1'b0;
          w_busy_next        = 1'b1;
          w_w_out_next       = data[0];
        end
      end

      S_SHIFT: begin
        w_busy_next = 1'b1;
        w_run_next  = w_run_upd;
        w_z_next    = w_hit;
        if (w_hit) begin
          w_match_count_next = r_match_count + CNT_W'(1);
          if (!r_found) begin
            w_first_pos_next = CNT_W'(r_idx);
            w_found_next     = 1'b1;
          end
        end
        if (w_last_bit) begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
        end else begin
          w_idx_next   = w_idx_inc;
          w_w_out_next = r_data[w_idx_inc];
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
        w_run_next   = '0;
      end

      default: begin
        w_state_next = S_IDLE;
        w_run_next   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_data        <= '0;
      r_cfg         <= '0;
      r_idx         <= '0;
      r_run         <= '0;
      r_match_count <= '0;
      r_first_pos   <= '0;
      r_found       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_w_out       <= 1'b0;
      r_z           <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_data        <= w_data_next;
      r_cfg         <= w_cfg_next;
      r_idx         <= w_idx_next;
      r_run         <= w_run_next;
      r_match_count <= w_match_count_next;
      r_first_pos   <= w_first_pos_next;
      r_found       <= w_found_next;
      r_busy        <= w_busy_next;
      r_done        <= w_done_next;
      r_w_out       <= w_w_out_next;
      r_z           <= w_z_next;
    end
  end

  assign busy        = r_busy;
  assign w_out       = r_w_out;
  assign z           = r_z;
  assign done        = r_done;
  assign match_count = r_match_count;
  assign first_pos   = r_first_pos;
  assign found       = r_found;

endmodule

// File: tb/tb_secuencia_ctrl.sv
// Scoreboard bench for secuencia_ctrl: stimulus pushes expected pass results,
// a negedge monitor collects serial/z traces and checks them at each done pulse.
module tb_secuencia_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] data;
  logic [2:0] run_len;
  logic       busy;
  logic       w_out;
  logic       z;
  logic       done;
  logic [3:0] match_count;
  logic [3:0] first_pos;
  logic       found;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] w;
    logic [8:0] zt;
    logic [3:0] cnt;
    logic [3:0] fp;
    logic       fnd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  secuencia_ctrl #(.WIDTH(8), .CNT_W(4), .RUN_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .data        (data),
    .run_len     (run_len),
    .busy        (busy),
    .w_out       (w_out),
    .z           (z),
    .done        (done),
    .match_count (match_count),
    .first_pos   (first_pos),
    .found       (found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: z trace index k is the z value while bit k (k<8) or DONE (k=8) is shown
  int         n;
  logic [7:0] wtr;
  logic [8:0] ztr;
  bit         post;

  always @(negedge clk) begin
    if (!reset) begin
      n = 0; wtr = '0; ztr = '0; post = 0;
    end else begin
      if (post) begin
        chk("done_width", {31'b0, done | busy}, 32'd0);
        post = 0;
      end
      if (done) begin
        ztr[8] = z;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pass pending");
        end else begin
          mon_e = sb.pop_front();
          chk("latency",   n,           32'd8);
          chk("w_trace",   wtr,         mon_e.w);
          chk("w_out_done", w_out,      32'd0);
          chk("z_trace",   ztr,         mon_e.zt);
          chk("match_count", match_count, mon_e.cnt);
          chk("first_pos", first_pos,   mon_e.fp);
          chk("found",     found,       mon_e.fnd);
        end
        n = 0; wtr = '0; ztr = '0; post = 1;
      end else if (busy) begin
        if (n < 8) begin
          wtr[n[2:0]] = w_out;
          ztr[n[3:0]] = z;
        end
        n++;
      end
    end
  end

  task automatic run_pass(input logic [7:0] d, input logic [2:0] rl, input logic [8:0] zt,
                          input logic [3:0] cnt, input logic [3:0] fp, input logic fnd,
                          input bit perturb);
    exp_t e;
    int   k;
    @(negedge clk);
    data = d; run_len = rl; start = 1'b1;
    e.w = d; e.zt = zt; e.cnt = cnt; e.fp = fp; e.fnd = fnd;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (perturb) begin
      repeat (2) @(negedge clk);
      start = 1'b1; data = ~d; run_len = 3'd1;
      @(negedge clk);
      start = 1'b0; data = 8'h00; run_len = 3'd0;
    end
    k = 0;
    while ((sb.size() != 0 || busy) && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", k);
      sb.delete();
    end
    @(negedge clk);
    chk("hold_count", match_count, cnt);
    chk("hold_first", first_pos,   fp);
    chk("hold_found", found,       fnd);
    chk("idle_z",     z,           32'd0);
    chk("idle_busy",  busy,        32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; data = 8'h00; run_len = 3'd0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  busy,        32'd0);
    chk("rst_w_out", w_out,       32'd0);
    chk("rst_z",     z,           32'd0);
    chk("rst_done",  done,        32'd0);
    chk("rst_count", match_count, 32'd0);
    chk("rst_first", first_pos,   32'd0);
    chk("rst_found", found,       32'd0);
    reset = 1'b1;

    run_pass(8'h06, 3'd2, 9'h008, 4'd1, 4'd2, 1'b1, 1'b0);
    run_pass(8'hFF, 3'd2, 9'h1FC, 4'd7, 4'd1, 1'b1, 1'b0);
    run_pass(8'h55, 3'd2, 9'h000, 4'd0, 4'd0, 1'b0, 1'b0);
    run_pass(8'h01, 3'd0, 9'h002, 4'd1, 4'd0, 1'b1, 1'b0);
    run_pass(8'hFF, 3'd7, 9'h180, 4'd2, 4'd6, 1'b1, 1'b1);

    // Abort a pass while bit 4 is presented
    @(negedge clk);
    data = 8'hFF; run_len = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", busy, 32'd1);
    chk("pre_abort_z",    z,    32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy",  busy,        32'd0);
    chk("abort_z",     z,           32'd0);
    chk("abort_done",  done,        32'd0);
    chk("abort_count", match_count, 32'd0);
    chk("abort_w_out", w_out,       32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_abort_busy", busy, 32'd0);
    chk("post_abort_done", done, 32'd0);

    run_pass(8'h03, 3'd2, 9'h004, 4'd1, 4'd1, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
